seq_detector_fsm: RTL and testbench

SEQ_DETECTOR_FSM -- requirements
Module: seq_detector_fsm

---
 rtl/seq_detector_fsm.sv | 123 ++++++++++++
 tb/tb_seq_detector_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_fsm.sv
// Serial pattern detector with KMP fallback, Mealy match output, registered
// match pulse and saturating match counter. Transition table fixed at elaboration.
module seq_detector_fsm #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8,
  parameter int                 SW      = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             clear,
  output logic             match,
  output logic             match_q,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            NST     = 1 << SW;
  localparam logic [SW-1:0] LAST_ST = SW'(PAT_W - 1);

  // Bit p of the pattern in arrival order (p = 0 is the first bit received).
  function automatic logic pat_bit(input int p);
    return PATTERN[PAT_W-1-p];
  endfunction

  // Longest suffix of (first s pattern bits, then b) that is also a pattern prefix,
  // limited to PAT_W-1 so the full-match case is handled separately.
  function automatic int kmp_next(input int s, input int b);
    int   best;
    int   idx;
    logic ok;
    logic sb;
    best = 0;
    for (int k = 1; k < PAT_W; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int m = 0; m < k; m++) begin
          idx = s + 1 - k + m;
          sb  = (idx == s) ? (b != 0) : pat_bit(idx);
          if (sb != pat_bit(m)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Longest proper suffix of the pattern that is also a prefix.
  function automatic int fail_len();
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < PAT_W; k++) begin
      ok = 1'b1;
      for (int m = 0; m < k; m++) begin
        if (pat_bit(PAT_W - k + m) != pat_bit(m)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  localparam logic [SW-1:0] FAIL_ST = SW'(fail_len());

  logic [SW-1:0]    r_state;
  logic             r_match_q;
  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    w_state_next;
  logic             w_match;
  logic [SW-1:0]    w_nxt_tbl [NST][2];

  // Unreachable encodings map to state 0 so a corrupted state recovers.
  for (genvar gi = 0; gi < NST; gi++) begin : g_st
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      if (gi < PAT_W) begin : g_legal
        localparam int NXT = kmp_next(gi, gb);
        assign w_nxt_tbl[gi][gb] = SW'(NXT);
      end else begin : g_illegal
        assign w_nxt_tbl[gi][gb] = '0;
      end
    end
  end

  always_comb begin
    w_match      = 1'b0;
    w_state_next = r_state;
    if (clear) begin
      w_state_next = '0;
    end else if (en) begin
      if ((r_state == LAST_ST) && (din == PATTERN[0])) begin
        w_match      = 1'b1;
        w_state_next = (OVERLAP != 0) ? FAIL_ST : '0;
      end else begin
        w_state_next = w_nxt_tbl[r_state][din];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= '0;
      r_match_q <= 1'b0;
      r_cnt     <= '0;
    end else if (clear) begin
      r_state   <= '0;
      r_match_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_match_q <= w_match;
      if (w_match && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match     = w_match & ~reset;
  assign match_q   = r_match_q;
  assign state     = r_state;
  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detector_fsm.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a history-based reference model for four configurations.
module tb_seq_detector_fsm;

  logic clk = 1'b0;
  logic reset, en, din, clear;

  logic       m_ov, mq_ov, m_no, mq_no, m_sat, mq_sat, m_p5, mq_p5;
  logic [1:0] st_ov, st_no, st_sat;
  logic [2:0] st_p5;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_sat;
  logic [3:0] cnt_p5;

  seq_detector_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .en(en), .din(din), .clear(clear),
    .match(m_ov), .match_q(mq_ov), .state(st_ov), .match_cnt(cnt_ov));
  seq_detector_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) u_no (
    .clk(clk), .reset(reset), .en(en), .din(din), .clear(clear),
    .match(m_no), .match_q(mq_no), .state(st_no), .match_cnt(cnt_no));
  seq_detector_fsm #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .din(din), .clear(clear),
    .match(m_sat), .match_q(mq_sat), .state(st_sat), .match_cnt(cnt_sat));
  seq_detector_fsm #(.PAT_W(5), .PATTERN(5'b11011), .OVERLAP(0), .CNT_W(4)) u_p5 (
    .clk(clk), .reset(reset), .en(en), .din(din), .clear(clear),
    .match(m_p5), .match_q(mq_p5), .state(st_p5), .match_cnt(cnt_p5));

  always #5 clk = ~clk;

  int a_st[4], a_cnt[4], a_m[4], a_mq[4];
  assign a_st[0] = int'(st_ov);   assign a_st[1] = int'(st_no);
  assign a_st[2] = int'(st_sat);  assign a_st[3] = int'(st_p5);
  assign a_cnt[0] = int'(cnt_ov); assign a_cnt[1] = int'(cnt_no);
  assign a_cnt[2] = int'(cnt_sat); assign a_cnt[3] = int'(cnt_p5);
  assign a_m[0] = int'(m_ov);     assign a_m[1] = int'(m_no);
  assign a_m[2] = int'(m_sat);    assign a_m[3] = int'(m_p5);
  assign a_mq[0] = int'(mq_ov);   assign a_mq[1] = int'(mq_no);
  assign a_mq[2] = int'(mq_sat);  assign a_mq[3] = int'(mq_p5);

  int checks = 0;
  int failures = 0;

  // Reference model: bit history since the last restart point (newest bit in LSB).
  int pw[4], patv[4], ov[4], cmax[4];
  int hist[4], hlen[4], mcnt[4], mq[4], em[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int ref_state(input int i);
    for (int k = pw[i] - 1; k >= 1; k--) begin
      if (k <= hlen[i] && (hist[i] & ((1 << k) - 1)) == (patv[i] >> (pw[i] - k)))
        return k;
    end
    return 0;
  endfunction

  function automatic int ref_match(input int i);
    int h2;
    h2 = ((hist[i] << 1) | int'(din)) & 16'hFFFF;
    if (en !== 1'b1 || clear !== 1'b0 || reset !== 1'b0) return 0;
    if (hlen[i] + 1 < pw[i]) return 0;
    return ((h2 & ((1 << pw[i]) - 1)) == patv[i]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist[i] = 0; hlen[i] = 0; mcnt[i] = 0; mq[i] = 0; em[i] = 0;
    end
  endtask

  task automatic push(input int i);
    hist[i] = ((hist[i] << 1) | int'(din)) & 16'hFFFF;
    hlen[i] = (hlen[i] < 16) ? hlen[i] + 1 : 16;
  endtask

  task automatic drive(input logic e, input logic d, input logic c);
    en = e; din = d; clear = c;
  endtask

  task automatic check_now();
    for (int i = 0; i < 4; i++) begin
      em[i] = ref_match(i);
      chk($sformatf("u%0d_state", i), a_st[i], ref_state(i));
      chk($sformatf("u%0d_match", i), a_m[i], em[i]);
      chk($sformatf("u%0d_match_q", i), a_mq[i], mq[i]);
      chk($sformatf("u%0d_cnt", i), a_cnt[i], mcnt[i]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (clear) begin
        hist[i] = 0; hlen[i] = 0; mcnt[i] = 0; mq[i] = 0;
      end else begin
        if (en) begin
          if (em[i] != 0) begin
            if (mcnt[i] < cmax[i]) mcnt[i]++;
            if (ov[i] != 0) push(i);
            else begin hist[i] = 0; hlen[i] = 0; end
          end else begin
            push(i);
          end
        end
        mq[i] = em[i];
      end
    end
    #1;
  endtask

  task automatic cycle(input logic e, input logic d, input logic c);
    drive(e, d, c);
    @(negedge clk);
    check_now();
    advance();
  endtask

  task automatic do_reset();
    en = 1'b0; clear = 1'b0; reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_u%0d_state", i), a_st[i], 0);
      chk($sformatf("rst_u%0d_match", i), a_m[i], 0);
      chk($sformatf("rst_u%0d_match_q", i), a_mq[i], 0);
      chk($sformatf("rst_u%0d_cnt", i), a_cnt[i], 0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic e, d, c;
    int   m1, s1, c1;
    int   m0, s0, c0;
  } vec_t;
  vec_t tbl[17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    pw   = '{4, 4, 4, 5};
    patv = '{4'b1011, 4'b1011, 4'b1011, 5'b11011};
    ov   = '{1, 0, 1, 0};
    cmax = '{255, 255, 3, 15};
    din = 1'b0;
    do_reset();

    // {en,din,clear, overlap: match,state,cnt, non-overlap: match,state,cnt}
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 1, 0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 0, 2, 0, 0, 2, 0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1, 3, 0, 1, 3, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 0, 1, 1, 0, 0, 1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 0, 2, 1, 0, 0, 1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1, 3, 1, 0, 1, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 0, 1, 2, 0, 1, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 0, 1, 2, 0, 1, 1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 0, 1, 0, 0, 1, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 0, 2, 0, 0, 2, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 0, 3, 0, 0, 3, 0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 0, 2, 0, 0, 2, 0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1, 3, 0, 1, 3, 0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 0, 1, 1, 0, 0, 1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 0, 1, 1, 0, 0, 1};

    for (int v = 0; v < 17; v++) begin
      drive(tbl[v].e, tbl[v].d, tbl[v].c);
      @(negedge clk);
      check_now();
      chk($sformatf("vec%0d_ov_match", v), a_m[0], tbl[v].m1);
      chk($sformatf("vec%0d_ov_state", v), a_st[0], tbl[v].s1);
      chk($sformatf("vec%0d_ov_cnt", v), a_cnt[0], tbl[v].c1);
      chk($sformatf("vec%0d_no_match", v), a_m[1], tbl[v].m0);
      chk($sformatf("vec%0d_no_state", v), a_st[1], tbl[v].s0);
      chk($sformatf("vec%0d_no_cnt", v), a_cnt[1], tbl[v].c0);
      $display("vec %0d en=%0d din=%0d clr=%0d ov:m=%0d s=%0d c=%0d no:m=%0d s=%0d c=%0d",
               v, en, din, clear, a_m[0], a_st[0], a_cnt[0], a_m[1], a_st[1], a_cnt[1]);
      advance();
    end

    // en gaps between the bits of 1011: state holds, one match only
    do_reset();
    cycle(1, 1, 0); cycle(0, 0, 0); cycle(0, 1, 0);
    chk("gap_state_hold", a_st[0], 1);
    cycle(1, 0, 0); cycle(0, 1, 0); cycle(1, 1, 0);
    cycle(0, 0, 0); cycle(0, 1, 0); cycle(1, 1, 0);
    chk("gap_cnt", a_cnt[0], 1);
    $display("gap seq cnt=%0d state=%0d", a_cnt[0], a_st[0]);

    // five overlapping matches: 2-bit counter saturates at 3
    do_reset();
    begin
      logic [15:0] bits;
      bits = 16'b1011_011_011_011_011;
      for (int b = 15; b >= 0; b--) cycle(1, bits[b], 0);
    end
    chk("sat_cnt", a_cnt[2], 3);
    chk("sat_ov_cnt", a_cnt[0], 5);
    $display("saturation cnt2=%0d cnt8=%0d", a_cnt[2], a_cnt[0]);

    // reset after a partial 1,0,1 discards it; a lone 1 then must not match
    cycle(1, 1, 0); cycle(1, 0, 0); cycle(1, 1, 0);
    chk("pre_reset_state", a_st[0], 3);
    do_reset();
    drive(1, 1, 0);
    @(negedge clk);
    check_now();
    chk("post_reset_no_match", a_m[0], 0);
    advance();
    $display("reset mid-seq state=%0d cnt=%0d", a_st[0], a_cnt[0]);

    // clear coincident with the final bit: no match, nothing counted or registered
    do_reset();
    cycle(1, 1, 0); cycle(1, 0, 0); cycle(1, 1, 0);
    drive(1, 1, 1);
    @(negedge clk);
    check_now();
    chk("clr_final_match", a_m[0], 0);
    advance();
    chk("clr_match_q", a_mq[0], 0);
    chk("clr_cnt", a_cnt[0], 0);
    chk("clr_state", a_st[0], 0);
    $display("clear on final bit match_q=%0d cnt=%0d", a_mq[0], a_cnt[0]);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
              logic'($urandom_range(0, 39) == 0));
      end
    end
    $display("random phase done cnt=%0d/%0d/%0d/%0d", a_cnt[0], a_cnt[1], a_cnt[2], a_cnt[3]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
